// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receiver family: parity modes, FSM encoding,
// and the tick-counter width helper.
package rs232_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/rs232_rx_sync.sv
// Two-flop synchroniser for the serial line plus a qualified 1->0 start-edge detector.
module rs232_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic start_edge
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q, prev_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;

    // The flops reset high, so a line held low through reset would look like an
    // edge; edges are only accepted once a real high level has been synchronised.
    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & sync2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
        end
    end

    assign rx_s       = sync2_q;
    assign start_edge = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/rs232_rx_ext.sv
// Parametrised RS232 receiver: majority-voted sampling, parity/framing/break
// detection, and a one-word holding register behind a valid/ready handshake.
module rs232_rx_ext
    import rs232_pkg::*;
#(
    parameter int CLK_DIVIDER = 3125,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int CW   = cnt_width(CLK_DIVIDER);
    localparam int HALF = CLK_DIVIDER / 2;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIVIDER - 1);
    localparam logic [CW-1:0] SMP0      = CW'(HALF - 1);
    localparam logic [CW-1:0] SMP1      = CW'(HALF);
    localparam logic [CW-1:0] SMP2      = CW'(HALF + 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_INV   = (PARITY_MODE == PARITY_ODD);

    logic rx_s, start_edge;

    rs232_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [1:0]            smp_q, smp_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  par_err_q, par_err_d;
    logic                  par_zero_q, par_zero_d;
    logic                  frm_err_q, frm_err_d;
    logic                  stop0_zero_q, stop0_zero_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  break_q, break_d;
    logic                  overrun_q, overrun_d;

    logic maj, at_mid, at_last, done;
    logic fin_fe, fin_bk;

    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        bit_cnt_d     = bit_cnt_q;
        stop_idx_d    = stop_idx_q;
        smp_d         = smp_q;
        shreg_d       = shreg_q;
        par_err_d     = par_err_q;
        par_zero_d    = par_zero_q;
        frm_err_d     = frm_err_q;
        stop0_zero_d  = stop0_zero_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = frame_err_q;
        parity_err_d  = parity_err_q;
        break_d       = break_q;
        overrun_d     = 1'b0;
        done          = 1'b0;

        at_mid  = (cnt_q == SMP2);
        at_last = (cnt_q == CNT_LAST);
        // Third sample is taken live, so the vote resolves at count HALF+1.
        maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
        if (cnt_q == SMP0) smp_d[0] = rx_s;
        if (cnt_q == SMP1) smp_d[1] = rx_s;

        fin_fe = frm_err_q | ~maj;
        fin_bk = (shreg_q == '0) & par_zero_q & ((stop_idx_q == 1'b0) ? ~maj : stop0_zero_q);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d      = ST_START;
                    bit_cnt_d    = '0;
                    stop_idx_d   = 1'b0;
                    par_err_d    = 1'b0;
                    par_zero_d   = 1'b1;
                    frm_err_d    = 1'b0;
                    stop0_zero_d = 1'b0;
                end
            end
            ST_START: begin
                if (at_mid && maj) state_d = ST_IDLE;
                else if (at_last)  state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_mid) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (at_last) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_mid) begin
                    par_zero_d = ~maj;
                    par_err_d  = maj ^ (^shreg_q) ^ ODD_INV;
                end
                if (at_last) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (at_mid) begin
                    if (!maj) frm_err_d = 1'b1;
                    if (stop_idx_q == 1'b0) stop0_zero_d = ~maj;
                    // Complete at the vote, not the bit end, so a back-to-back start is seen.
                    if (stop_idx_q == STOP_LAST) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (at_last) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shreg_q;
                rx_valid_d   = 1'b1;
                frame_err_d  = fin_fe;
                parity_err_d = par_err_q;
                break_d      = fin_bk;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            stop_idx_q   <= 1'b0;
            smp_q        <= 2'b11;
            shreg_q      <= '0;
            par_err_q    <= 1'b0;
            par_zero_q   <= 1'b1;
            frm_err_q    <= 1'b0;
            stop0_zero_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_idx_q   <= stop_idx_d;
            smp_q        <= smp_d;
            shreg_q      <= shreg_d;
            par_err_q    <= par_err_d;
            par_zero_q   <= par_zero_d;
            frm_err_q    <= frm_err_d;
            stop0_zero_q <= stop0_zero_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_q      <= break_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign break_det  = break_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rs232_rx_ext.sv
// Bench for rs232_rx_ext: three configurations (8N1, 8E1, 7O2) at 16 clocks/bit,
// directed vector table, multi-cycle corner sequences and a randomized model check.
module tb_rs232_rx_ext;

    localparam int DIV = 16;

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bk;
    } word_t;

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stops;
        logic [8:0] e_data;
        logic       e_pe;
        logic       e_fe;
        logic       e_bk;
    } vec_t;

    int nb_c [3] = '{8, 8, 7};
    int pm_c [3] = '{0, 1, 2};
    int ns_c [3] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_ready = 1'b1;
    logic [2:0] rx_l = 3'b111;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] v, fe, pe, bk, ov;

    int    n_vec = 0;
    int    n_bad = 0;
    int    vcyc [3] = '{0, 0, 0};
    int    ovc  [3] = '{0, 0, 0};
    word_t q [$];

    always #5 clk = ~clk;

    rs232_rx_ext #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .rx_data(d0), .rx_valid(v[0]), .rx_ready(rx_ready),
        .frame_err(fe[0]), .parity_err(pe[0]), .break_det(bk[0]), .overrun(ov[0]));
    rs232_rx_ext #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .rx_data(d1), .rx_valid(v[1]), .rx_ready(rx_ready),
        .frame_err(fe[1]), .parity_err(pe[1]), .break_det(bk[1]), .overrun(ov[1]));
    rs232_rx_ext #(.CLK_DIVIDER(DIV), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .rx_data(d2), .rx_valid(v[2]), .rx_ready(rx_ready),
        .frame_err(fe[2]), .parity_err(pe[2]), .break_det(bk[2]), .overrun(ov[2]));

    function automatic logic [8:0] dout(input int i);
        case (i)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return {2'b00, d2};
        endcase
    endfunction

    // Monitor: collect handshaken words, valid-high cycles and overrun pulses.
    always @(negedge clk) begin
        word_t w;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (v[i]) vcyc[i]++;
            if (ov[i]) ovc[i]++;
            if (v[i] && rx_ready) begin
                w.dut = i; w.data = dout(i); w.pe = pe[i]; w.fe = fe[i]; w.bk = bk[i];
                q.push_back(w);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: frame outcome from the line-level rules, independent of timing.
    function automatic word_t model(input int i, input logic [8:0] data, input logic pbit,
                                    input logic [1:0] stops);
        word_t      m;
        logic [8:0] mask;
        int         ones;
        logic       want;
        mask   = 9'((1 << nb_c[i]) - 1);
        m.dut  = i;
        m.data = data & mask;
        ones   = $countones(m.data);
        want   = ((ones % 2) == 1) ^ (pm_c[i] == 2);
        m.pe   = (pm_c[i] != 0) && (pbit != want);
        m.fe   = (stops[0] == 1'b0) || (ns_c[i] == 2 && stops[1] == 1'b0);
        m.bk   = (m.data == 9'd0) && (pm_c[i] == 0 || pbit == 1'b0) && (stops[0] == 1'b0);
        return m;
    endfunction

    // Drives one frame plus one idle bit; gbit selects a bit to spike for one clock near its middle.
    task automatic send(input int i, input logic [8:0] data, input logic pbit,
                        input logic [1:0] stops, input int gbit);
        logic [15:0] bits;
        int n;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int k = 0; k < nb_c[i]; k++) begin bits[n] = data[k]; n++; end
        if (pm_c[i] != 0) begin bits[n] = pbit; n++; end
        for (int s = 0; s < ns_c[i]; s++) begin bits[n] = stops[s]; n++; end
        n++;
        @(negedge clk);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < DIV; c++) begin
                rx_l[i] = (b == gbit && c == 9) ? ~bits[b] : bits[b];
                @(negedge clk);
            end
        end
    endtask

    task automatic expect_word(input int i, input logic [8:0] ed, input logic epe,
                               input logic efe, input logic ebk, input string nm);
        word_t w;
        int t;
        t = 0;
        while (q.size() == 0 && t < 64) begin @(negedge clk); t++; end
        if (q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL %s: no word received, expected data 0x%0h", nm, ed);
        end else begin
            w = q.pop_front();
            cmp({nm, ".dut"}, 32'(w.dut), 32'(i));
            cmp({nm, ".data"}, 32'(w.data), 32'(ed));
            cmp({nm, ".parity_err"}, 32'(w.pe), 32'(epe));
            cmp({nm, ".frame_err"}, 32'(w.fe), 32'(efe));
            cmp({nm, ".break_det"}, 32'(w.bk), 32'(ebk));
        end
    endtask

    initial begin
        vec_t  vt [7];
        word_t m;
        int    lat, exp_lat, vc0, o0, idx;
        logic [8:0] rd;
        logic  rp;
        logic [1:0] rs;

        vt[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1, 9'h003, 1'b1, 2'b11, 9'h003, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1, 9'h003, 1'b0, 2'b11, 9'h003, 1'b0, 1'b0, 1'b0};
        vt[3] = '{2, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0, 1'b0};
        vt[4] = '{0, 9'h055, 1'b0, 2'b10, 9'h055, 1'b0, 1'b1, 1'b0};
        vt[5] = '{2, 9'h000, 1'b0, 2'b10, 9'h000, 1'b1, 1'b1, 1'b1};
        vt[6] = '{1, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        cmp("reset.valid", 32'(v), 32'd0);
        cmp("reset.flags", 32'({fe, pe, bk, ov}), 32'd0);
        cmp("reset.data", 32'({d0, d1, d2}), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        cmp("idle.valid", 32'(v), 32'd0);

        for (int k = 0; k < 7; k++) begin
            idx = vt[k].dut;
            vc0 = vcyc[idx];
            exp_lat = 3 + (nb_c[idx] + (pm_c[idx] != 0 ? 1 : 0) + ns_c[idx]) * DIV + 10;
            lat = 0;
            fork
                send(idx, vt[k].data, vt[k].pbit, vt[k].stops, -1);
                begin
                    @(negedge clk);
                    while (!v[idx] && lat < 400) begin @(negedge clk); lat++; end
                end
            join
            n_vec++;
            if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
                n_bad++;
                $display("FAIL vec%0d.latency: got %0d expected %0d", k, lat, exp_lat);
            end
            expect_word(idx, vt[k].e_data, vt[k].e_pe, vt[k].e_fe, vt[k].e_bk, $sformatf("vec%0d", k));
            cmp($sformatf("vec%0d.valid_cycles", k), 32'(vcyc[idx] - vc0), 32'd1);
        end

        // Short low pulse is a false start; then a spiked 0x55 must survive the vote.
        vc0 = vcyc[0];
        @(negedge clk);
        rx_l[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        cmp("glitch.words", 32'(q.size()), 32'd0);
        cmp("glitch.valid_cycles", 32'(vcyc[0] - vc0), 32'd0);
        send(0, 9'h055, 1'b0, 2'b11, 4);
        expect_word(0, 9'h055, 1'b0, 1'b0, 1'b0, "spike");

        // Line held low for 20 bit times reports exactly one break word.
        vc0 = vcyc[0];
        @(negedge clk);
        rx_l[0] = 1'b0;
        repeat (20 * DIV) @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        expect_word(0, 9'h000, 1'b0, 1'b1, 1'b1, "break");
        cmp("break.extra_words", 32'(q.size()), 32'd0);
        cmp("break.valid_cycles", 32'(vcyc[0] - vc0), 32'd1);

        // Holding register full: second frame is dropped with one overrun pulse.
        o0 = ovc[0];
        rx_ready = 1'b0;
        send(0, 9'h011, 1'b0, 2'b11, -1);
        send(0, 9'h022, 1'b0, 2'b11, -1);
        cmp("ovr.valid", 32'(v[0]), 32'd1);
        cmp("ovr.data", 32'(d0), 32'h11);
        cmp("ovr.pulses", 32'(ovc[0] - o0), 32'd1);
        cmp("ovr.words", 32'(q.size()), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        #2;
        cmp("ovr.drained_valid", 32'(v[0]), 32'd0);
        expect_word(0, 9'h011, 1'b0, 1'b0, 1'b0, "ovr.drain");
        cmp("ovr.extra_words", 32'(q.size()), 32'd0);

        // Handshake in the completion cycle: new word loads, no overrun.
        rx_ready = 1'b0;
        send(0, 9'h033, 1'b0, 2'b11, -1);
        o0 = ovc[0];
        fork
            send(0, 9'h044, 1'b0, 2'b11, -1);
            begin
                repeat (157) @(negedge clk);
                rx_ready = 1'b1;
            end
        join
        expect_word(0, 9'h033, 1'b0, 1'b0, 1'b0, "simul.old");
        expect_word(0, 9'h044, 1'b0, 1'b0, 1'b0, "simul.new");
        cmp("simul.overrun", 32'(ovc[0] - o0), 32'd0);

        // Reset mid-frame with a word held, release with the line low.
        rx_ready = 1'b0;
        send(0, 9'h05A, 1'b0, 2'b11, -1);
        cmp("rst.held_valid", 32'(v[0]), 32'd1);
        @(negedge clk);
        rx_l[0] = 1'b0;
        repeat (DIV) @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        rx_l[0] = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("rst.valid", 32'(v[0]), 32'd0);
        cmp("rst.data", 32'(d0), 32'd0);
        cmp("rst.flags", 32'({fe[0], pe[0], bk[0], ov[0]}), 32'd0);
        repeat (4) @(negedge clk);
        rx_ready = 1'b1;
        rst_n = 1'b1;
        repeat (14 * DIV) @(negedge clk);
        cmp("rst.low_words", 32'(q.size()), 32'd0);
        cmp("rst.low_valid", 32'(v[0]), 32'd0);
        rx_l[0] = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        send(0, 9'h03C, 1'b0, 2'b11, -1);
        expect_word(0, 9'h03C, 1'b0, 1'b0, 1'b0, "rst.next");

        // Randomized frames against the reference model.
        for (int r = 0; r < 30; r++) begin
            idx = $urandom_range(0, 2);
            rd  = 9'($urandom);
            if ($urandom_range(0, 7) == 0) rd = 9'd0;
            rp  = 1'($urandom_range(0, 1));
            rs[0] = ($urandom_range(0, 3) != 0);
            rs[1] = ($urandom_range(0, 3) != 0);
            m = model(idx, rd, rp, rs);
            send(idx, rd, rp, rs, -1);
            expect_word(idx, m.data, m.pe, m.fe, m.bk, $sformatf("rand%0d", r));
        end
        cmp("end.words", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
